// File: rtl/mem2io_bridge.sv
// CPU-side memory-mapped I/O bridge: decodes a small I/O window plus an event
// register in front of the SRAM, with synchronised inputs and byte-lane outputs.
module mem2io_bridge #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 20,
  parameter int          NUM_IO      = 4,
  parameter logic [15:0] IO_BASE     = 16'hFFFC,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [ADDR_W-1:0]        ADDR,
  input  logic                     CE,
  input  logic                     UB,
  input  logic                     LB,
  input  logic                     OE,
  input  logic                     WE,
  input  logic [NUM_IO*DATA_W-1:0] Switches,
  input  logic [DATA_W-1:0]        Data_from_CPU,
  input  logic [DATA_W-1:0]        Data_from_SRAM,
  output logic [DATA_W-1:0]        Data_to_CPU,
  output logic [DATA_W-1:0]        Data_to_SRAM,
  output logic [NUM_IO*DATA_W-1:0] IO_Out,
  output logic                     IO_Sel,
  output logic                     Event_Irq
);

  localparam int HALF = DATA_W / 2;
  localparam int IOW  = NUM_IO * DATA_W;

  logic [15:0] addrLow;
  logic [NUM_IO-1:0] chanSel;
  logic chanHit;
  logic evtHit;
  logic wr;
  logic rd;
  logic wrCommit;
  logic rdCommit;

  logic [SYNC_STAGES-1:0][IOW-1:0] syncReg_q;
  logic [NUM_IO-1:0][DATA_W-1:0]   swSync;
  logic [NUM_IO-1:0][DATA_W-1:0]   swPrev_q;
  logic [NUM_IO-1:0][DATA_W-1:0]   ioReg_q;
  logic [NUM_IO-1:0][DATA_W-1:0]   ioReg_d;
  logic [NUM_IO-1:0]               evt_q;
  logic [NUM_IO-1:0]               evt_d;
  logic [NUM_IO-1:0]               changed;
  logic [DATA_W-1:0]               chanWord;
  logic                            wr_q;
  logic                            rd_q;

  assign addrLow = ADDR[15:0];

  // Only the low 16 address bits take part in the decode.
  if (ADDR_W > 16) begin : gUpperAddr
    logic unusedAddrHi;
    assign unusedAddrHi = ^ADDR[ADDR_W-1:16];
  end

  always_comb begin
    chanSel = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if ({1'b0, addrLow} == (17'(IO_BASE) + 17'(i))) begin
        chanSel[i] = 1'b1;
      end
    end
  end

  assign chanHit = |chanSel;
  assign evtHit  = (addrLow == 16'(IO_BASE - 16'd1));
  assign IO_Sel  = chanHit | evtHit;

  assign wr       = ~CE & ~WE;
  assign rd       = ~CE & ~OE & WE;
  assign wrCommit = wr & ~wr_q;
  assign rdCommit = rd & ~rd_q;

  assign swSync = syncReg_q[SYNC_STAGES-1];

  always_comb begin
    changed  = '0;
    chanWord = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      changed[i] = (swSync[i] != swPrev_q[i]);
      if (chanSel[i]) begin
        chanWord = chanWord | swSync[i];
      end
    end
  end

  always_comb begin
    Data_to_CPU = '0;
    if (rd) begin
      if (chanHit) begin
        Data_to_CPU = chanWord;
      end else if (evtHit) begin
        Data_to_CPU = DATA_W'(evt_q);
      end else begin
        Data_to_CPU = Data_from_SRAM;
      end
    end
  end

  always_comb begin
    ioReg_d = ioReg_q;
    if (wrCommit) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (chanSel[i]) begin
          if (!UB) ioReg_d[i][DATA_W-1:HALF] = Data_from_CPU[DATA_W-1:HALF];
          if (!LB) ioReg_d[i][HALF-1:0]      = Data_from_CPU[HALF-1:0];
        end
      end
    end
  end

  // A fresh change outranks the clear-on-read for the same bit.
  assign evt_d = ((rdCommit & evtHit) ? '0 : evt_q) | changed;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      syncReg_q <= '0;
      swPrev_q  <= '0;
      ioReg_q   <= '0;
      evt_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        syncReg_q <= {syncReg_q[SYNC_STAGES-2:0], Switches};
      end else begin
        syncReg_q <= Switches;
      end
      swPrev_q <= swSync;
      ioReg_q  <= ioReg_d;
      evt_q    <= evt_d;
      wr_q     <= wr;
      rd_q     <= rd;
    end
  end

  assign IO_Out       = ioReg_q;
  assign Data_to_SRAM = Data_from_CPU;
  assign Event_Irq    = |evt_q;

endmodule

// File: tb/tb_mem2io_bridge.sv
// Directed bench for mem2io_bridge: a decode/read vector table plus hand-built
// sequences for strobe edges, byte lanes, synchroniser latency and events.
module tb_mem2io_bridge;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [19:0] ADDR;
  logic        CE, UB, LB, OE, WE;
  logic [63:0] Switches;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Data_to_CPU;
  logic [15:0] Data_to_SRAM;
  logic [63:0] IO_Out;
  logic        IO_Sel;
  logic        Event_Irq;

  int passCount = 0;
  int totalCount = 0;

  typedef struct {
    logic [19:0] addr;
    logic        ce, oe, we, ub, lb;
    logic [15:0] din;
    logic [15:0] sram;
    logic [15:0] expData;
    logic        expSel;
  } vec_t;

  vec_t vecs [10];

  mem2io_bridge dut (
    .Clk(Clk),
    .Reset(Reset),
    .ADDR(ADDR),
    .CE(CE),
    .UB(UB),
    .LB(LB),
    .OE(OE),
    .WE(WE),
    .Switches(Switches),
    .Data_from_CPU(Data_from_CPU),
    .Data_from_SRAM(Data_from_SRAM),
    .Data_to_CPU(Data_to_CPU),
    .Data_to_SRAM(Data_to_SRAM),
    .IO_Out(IO_Out),
    .IO_Sel(IO_Sel),
    .Event_Irq(Event_Irq)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [19:0] addr, input logic ce, input logic oe,
                               input logic we, input logic ub, input logic lb,
                               input logic [15:0] din);
    ADDR = addr;
    CE = ce;
    OE = oe;
    WE = we;
    UB = ub;
    LB = lb;
    Data_from_CPU = din;
  endtask

  task automatic idleBus();
    CE = 1'b1;
    OE = 1'b1;
    WE = 1'b1;
    UB = 1'b1;
    LB = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{20'h01234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0};
    vecs[1] = '{20'h01234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h0000, 1'b0};
    vecs[2] = '{20'h0FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h00F0, 1'b1};
    vecs[3] = '{20'h0FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h4444, 1'b1};
    vecs[4] = '{20'h1FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h1111, 1'b1};
    vecs[5] = '{20'hAFFFD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h2222, 1'b1};
    vecs[6] = '{20'h0FFFD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9999, 16'h5A5A, 16'h0000, 1'b1};
    vecs[7] = '{20'h0FFFB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h0000, 1'b1};
    vecs[8] = '{20'h0FFF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hC3C3, 16'hC3C3, 1'b0};
    vecs[9] = '{20'h0FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b1};

    Reset = 1'b1;
    ADDR = 20'h0;
    Switches = 64'h0;
    Data_from_CPU = 16'h0;
    Data_from_SRAM = 16'h0;
    idleBus();
    tick();
    tick();
    checkOutput("reset IO_Out", IO_Out, 64'h0);
    checkOutput("reset Event_Irq", {63'h0, Event_Irq}, 64'h0);
    checkOutput("reset Data_to_CPU idle", {48'h0, Data_to_CPU}, 64'h0);
    Reset = 1'b0;
    tick();

    // Held write commits exactly once even though the data keeps changing.
    applyStimulus(20'h0FFFD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    #1;
    checkOutput("write IO_Sel", {63'h0, IO_Sel}, 64'h1);
    checkOutput("Data_to_SRAM passthrough", {48'h0, Data_to_SRAM}, 64'h0000_0000_0000_BEEF);
    tick();
    checkOutput("held write first commit", IO_Out, 64'h0000_0000_BEEF_0000);
    Data_from_CPU = 16'h1111;
    for (int k = 0; k < 4; k++) tick();
    checkOutput("held write single commit", IO_Out, 64'h0000_0000_BEEF_0000);
    idleBus();
    tick();

    applyStimulus(20'h0FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA);
    tick();
    idleBus();
    tick();
    applyStimulus(20'h0FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    tick();
    idleBus();
    checkOutput("upper byte lane", IO_Out, 64'h0000_0000_BEEF_12AA);
    tick();
    applyStimulus(20'h0FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5678);
    tick();
    idleBus();
    checkOutput("lower byte lane", IO_Out, 64'h0000_0000_BEEF_1278);
    tick();
    applyStimulus(20'h0FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    tick();
    idleBus();
    tick();
    applyStimulus(20'h0FFFB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    tick();
    idleBus();
    tick();
    checkOutput("no-lane and evt writes ignored", IO_Out, 64'h0000_0000_BEEF_1278);
    applyStimulus(20'h0FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F);
    tick();
    idleBus();
    checkOutput("write top channel", IO_Out, 64'h0F0F_0000_BEEF_1278);
    tick();

    // Synchroniser latency and event set.
    Switches = 64'h0000_00F0_0000_0000;
    applyStimulus(20'h0FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    #1;
    checkOutput("sync read before edge", {48'h0, Data_to_CPU}, 64'h0);
    tick();
    checkOutput("sync read after 1 edge", {48'h0, Data_to_CPU}, 64'h0);
    tick();
    checkOutput("sync read after 2 edges", {48'h0, Data_to_CPU}, 64'h00F0);
    checkOutput("irq not yet set", {63'h0, Event_Irq}, 64'h0);
    tick();
    checkOutput("irq set one cycle later", {63'h0, Event_Irq}, 64'h1);
    idleBus();
    tick();

    // Clear-on-read commits once while the read is held.
    applyStimulus(20'h0FFFB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    #1;
    checkOutput("event read value", {48'h0, Data_to_CPU}, 64'h0004);
    tick();
    checkOutput("event cleared after read", {48'h0, Data_to_CPU}, 64'h0);
    checkOutput("irq cleared after read", {63'h0, Event_Irq}, 64'h0);
    tick();
    tick();
    checkOutput("event stays clear", {48'h0, Data_to_CPU}, 64'h0);
    idleBus();
    tick();

    // Channel-0 change lands on the clear cycle: set wins for bit 0, bit 2 clears.
    Switches = 64'h0;
    tick();
    Switches = 64'h0000_0000_0000_0001;
    tick();
    tick();
    applyStimulus(20'h0FFFB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    #1;
    checkOutput("event before collide", {48'h0, Data_to_CPU}, 64'h0004);
    tick();
    checkOutput("set wins over clear", {48'h0, Data_to_CPU}, 64'h0001);
    checkOutput("irq after collide", {63'h0, Event_Irq}, 64'h1);
    tick();
    checkOutput("held read no second clear", {48'h0, Data_to_CPU}, 64'h0001);
    idleBus();
    tick();
    applyStimulus(20'h0FFFB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    idleBus();
    checkOutput("second read clears", {63'h0, Event_Irq}, 64'h0);
    tick();

    // Decode and read-mux table.
    Switches = 64'h4444_00F0_2222_1111;
    tick();
    tick();
    tick();
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].ce, vecs[v].oe, vecs[v].we,
                    vecs[v].ub, vecs[v].lb, vecs[v].din);
      Data_from_SRAM = vecs[v].sram;
      #1;
      checkOutput($sformatf("vec%0d Data_to_CPU", v), {48'h0, Data_to_CPU}, {48'h0, vecs[v].expData});
      checkOutput($sformatf("vec%0d IO_Sel", v), {63'h0, IO_Sel}, {63'h0, vecs[v].expSel});
      tick();
      idleBus();
      tick();
    end
    checkOutput("table left outputs intact", IO_Out, 64'h0F0F_0000_BEEF_1278);

    // Reset during a held write re-commits once afterwards.
    applyStimulus(20'h0FFFD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777);
    tick();
    checkOutput("pre-reset write", IO_Out, 64'h0F0F_0000_7777_1278);
    Reset = 1'b1;
    tick();
    checkOutput("mid-write reset clears", IO_Out, 64'h0);
    Reset = 1'b0;
    tick();
    checkOutput("post-reset recommit", IO_Out, 64'h0000_0000_7777_0000);
    Data_from_CPU = 16'h8888;
    tick();
    tick();
    checkOutput("post-reset single commit", IO_Out, 64'h0000_0000_7777_0000);
    idleBus();
    tick();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/mem2io_bridge.md
Name: mem2io_bridge

Overview:
Parametrised CPU-side memory-mapped I/O bridge between the CPU bus, external SRAM and board I/O. It generalises the single switch/hex-display location to NUM_IO channels. Each channel has a synchronised input word and a byte-lane-writable output register. The block also has an event register that latches input changes and clears on read. It sits between the CPU core and the SRAM pins in the top level, and drives the display/LED logic from IO_Out.

Parameters:
DATA_W, 16, bus data width; must be even (UB selects the upper half, LB the lower half)
ADDR_W, 20, CPU address width; decode uses ADDR[15:0] only
NUM_IO, 4, number of I/O channels, 1..DATA_W
IO_BASE, 16'hFFFC, address of channel 0; channel i sits at IO_BASE+i; IO_BASE+NUM_IO-1 must not exceed 16'hFFFF
SYNC_STAGES, 2, flip-flop stages on each Switches bit, >=2

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high
ADDR  in  ADDR_W  CPU address
CE  in  1  chip enable, active-low
UB  in  1  upper byte-lane enable, active-low
LB  in  1  lower byte-lane enable, active-low
OE  in  1  output enable (read), active-low
WE  in  1  write enable, active-low
Switches  in  NUM_IO*DATA_W  asynchronous board inputs; channel i occupies [i*DATA_W +: DATA_W]
Data_from_CPU  in  DATA_W  CPU write data
Data_from_SRAM  in  DATA_W  SRAM read data
Data_to_CPU  out  DATA_W  read data to CPU
Data_to_SRAM  out  DATA_W  write data to SRAM
IO_Out  out  NUM_IO*DATA_W  channel output registers, same packing as Switches
IO_Sel  out  1  high when ADDR[15:0] hits the I/O window or the EVT address; top level uses it to gate the SRAM CE
Event_Irq  out  1  OR-reduction of the event register

Behaviour:
- Address decode:
  - chan_hit = ADDR[15:0] in [IO_BASE, IO_BASE+NUM_IO-1]; chan = ADDR[15:0]-IO_BASE.
  - evt_hit = (ADDR[15:0] == IO_BASE-1).
  - IO_Sel = chan_hit | evt_hit, combinational.
- Access qualifiers:
  - wr = ~CE & ~WE.
  - rd = ~CE & ~OE & WE.
  - wr_q and rd_q are registered copies of wr and rd.
  - A write commits only on a cycle where wr & ~wr_q. A read-commit occurs only on a cycle where rd & ~rd_q. A strobe held low for many cycles therefore commits exactly once.
- Input path:
  - Every Switches bit passes through SYNC_STAGES flops, giving sw_s.
  - sw_p is the previous value of sw_s.
  - Channel i changed when sw_s[i] != sw_p[i] (any bit of the word).
- Read data (combinational):
  - Data_to_CPU = 0 unless rd.
  - If rd & chan_hit: sw_s[chan].
  - If rd & evt_hit: zero-extended event register.
  - Otherwise: Data_from_SRAM.
- Write path:
  - On a write-commit with chan_hit, IO_Out[chan] upper half loads from Data_from_CPU if ~UB, and the lower half loads if ~LB.
  - If both UB and LB are high, nothing is written.
  - Writes to evt_hit are ignored.
  - Data_to_SRAM = Data_from_CPU, always.
- Event register (NUM_IO bits):
  - Bit i sets on a channel-i change.
  - All bits clear on a read-commit with evt_hit.
  - When a set and a clear occur in the same cycle, set wins for that bit; other bits clear.
- Reset: IO_Out=0, event=0, sync/sw_p flops=0, wr_q=rd_q=0; Event_Irq=0. Data_to_CPU follows the combinational rule.
- Reset during a held strobe: because wr_q/rd_q are cleared, the first post-reset cycle with the strobe still low commits again.
- The first change after reset, from 0 to nonzero switches, sets events SYNC_STAGES+1 cycles after Reset deasserts.
- Latency:
  - Output register visible on IO_Out the cycle after commit.
  - Switch change visible on Data_to_CPU SYNC_STAGES cycles after it is sampled; event bit one cycle later.

Test Plan:
- Reset, then CE=0, WE=0, UB=LB=0, ADDR=16'hFFFD, Data_from_CPU=16'hBEEF held 5 cycles -> IO_Out[1]=16'hBEEF after 1 cycle, single commit; other channels 0; IO_Sel=1.
- Write 16'h1234 to 16'hFFFC with UB=0, LB=1, after a prior 16'hAAAA -> IO_Out[0]=16'h12AA.
- Switches channel 2 = 16'h00F0 held; read ADDR=16'hFFFE (OE=0, WE=1) -> Data_to_CPU=16'h00F0 after 2 sync cycles; event bit2=1 and Event_Irq=1 one cycle later.
- Read ADDR=16'hFFFB held 4 cycles -> returns 16'h0004 and events clear after the first cycle; a channel-0 change on the clear cycle leaves event=16'h0001.
- ADDR=16'h1234 read, Data_from_SRAM=16'h5A5A -> Data_to_CPU=16'h5A5A, IO_Sel=0; CE=1 -> Data_to_CPU=0.
- Assert Reset for 1 cycle mid-write with WE still low -> IO_Out cleared, then recommitted once on the first post-reset cycle.
